// File: rtl/pwm_ramp_controller.sv
// Soft-start/soft-stop duty sequencer for pwm_generator: ramps duty toward an accepted target,
// changing it only on PWM period boundaries. Optional target ceiling via `PWM_RAMP_CLAMP_EN`.
module pwm_ramp_controller #(
  parameter int WIDTH            = 8,
  parameter int STEP             = 8,
  parameter int PERIODS_PER_STEP = 4,
  parameter int DUTY_MAX         = 240
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [WIDTH-1:0] cmd_target,
  output logic             cmd_ready,
  input  logic             abort,
  output logic [WIDTH-1:0] duty_cycle,
  output logic             period_tick,
  output logic             busy,
  output logic             done
);

  localparam int               SC_W        = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
  localparam logic [SC_W-1:0]  STEP_LAST   = SC_W'(PERIODS_PER_STEP - 1);
  localparam logic [WIDTH:0]   STEP_W      = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] DUTY_MAX_W  = WIDTH'(DUTY_MAX);
  localparam logic [WIDTH-1:0] PERIOD_LAST = '1;

`ifdef PWM_RAMP_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] period_cnt;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] cmd_target_eff;
  logic [WIDTH-1:0] duty_step;
  logic [SC_W-1:0]  step_cnt, step_d;
  logic             done_d;

  // Upward step saturates at the target; the sum carries one extra bit so it cannot wrap.
  function automatic logic [WIDTH-1:0] ramp_up(input logic [WIDTH-1:0] cur,
                                               input logic [WIDTH-1:0] tgt);
    logic [WIDTH:0] sum;
    sum     = {1'b0, cur} + STEP_W;
    ramp_up = (sum >= {1'b0, tgt}) ? tgt : sum[WIDTH-1:0];
  endfunction

  // Downward step lands on the target whenever the remaining gap fits in one step.
  function automatic logic [WIDTH-1:0] ramp_down(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] tgt);
    logic [WIDTH-1:0] gap;
    gap       = cur - tgt;
    ramp_down = ({1'b0, gap} <= STEP_W) ? tgt : (cur - STEP_W[WIDTH-1:0]);
  endfunction

  function automatic logic [WIDTH-1:0] clamp_target(input logic [WIDTH-1:0] req);
    clamp_target = (CLAMP_EN && (req > DUTY_MAX_W)) ? DUTY_MAX_W : req;
  endfunction

  // Free-running period counter, aligned with pwm_generator's counter out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  assign period_tick = (period_cnt == PERIOD_LAST);

  always_comb begin
    state_d        = state_q;
    duty_d         = duty_q;
    target_d       = target_q;
    step_d         = step_cnt;
    done_d         = 1'b0;
    cmd_target_eff = clamp_target(cmd_target);
    duty_step      = (target_q > duty_q) ? ramp_up(duty_q, target_q)
                                         : ramp_down(duty_q, target_q);

    unique case (state_q)
      IDLE, HOLD: begin
        if (cmd_valid) begin
          target_d = cmd_target_eff;
          step_d   = '0;
          if (cmd_target_eff == duty_q) begin
            state_d = HOLD;
            done_d  = 1'b1;
          end else begin
            state_d = RAMP;
          end
        end
      end
      RAMP: begin
        // Abort wins over a coincident step so the duty freezes at its visible value.
        if (abort) begin
          state_d = HOLD;
          step_d  = '0;
        end else if (period_tick) begin
          if (step_cnt == STEP_LAST) begin
            step_d = '0;
            duty_d = duty_step;
            if (duty_step == target_q) begin
              state_d = HOLD;
              done_d  = 1'b1;
            end
          end else begin
            step_d = step_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Duty is registered on the edge that wraps period_cnt, so each PWM period sees one value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      target_q <= '0;
      step_cnt <= '0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      step_cnt <= step_d;
      done     <= done_d;
    end
  end

  assign duty_cycle = duty_q;
  assign cmd_ready  = (state_q != RAMP);
  assign busy       = (state_q == RAMP);

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Self-checking bench for pwm_ramp_controller: directed vector table, hand-written corner
// sequences and randomized commands against a closed-form model of the ramp.
module tb_pwm_ramp_controller;

  localparam int WIDTH    = 8;
  localparam int STEP     = 8;
  localparam int PPS      = 4;
  localparam int DUTY_MAX = 240;
  localparam int PERIOD   = 256;
  localparam int INF      = 32'h7fffffff;
`ifdef PWM_RAMP_CLAMP_EN
  localparam int FULL_FINAL = 240;
`else
  localparam int FULL_FINAL = 255;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [WIDTH-1:0] cmd_target = '0;
  logic             abort = 1'b0;
  logic             cmd_ready;
  logic [WIDTH-1:0] duty_cycle;
  logic             period_tick;
  logic             busy;
  logic             done;

  pwm_ramp_controller #(
    .WIDTH(WIDTH), .STEP(STEP), .PERIODS_PER_STEP(PPS), .DUTY_MAX(DUTY_MAX)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_target(cmd_target),
    .cmd_ready(cmd_ready), .abort(abort), .duty_cycle(duty_cycle),
    .period_tick(period_tick), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; the PWM period phase is edge_n mod PERIOD.
  int edge_n;
  always @(posedge clk or negedge reset) begin
    if (!reset) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  int n_chk, n_pass, done_total, done_base;
  bit mon_en = 1'b1;

  // Current command segment: accepted at edge m_a from duty m_d0 toward m_t, aborted at m_b.
  int m_a, m_d0, m_t;
  int m_b = INF;
  bit m_seg;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int clamp_t(input int x);
`ifdef PWM_RAMP_CLAMP_EN
    return (x > DUTY_MAX) ? DUTY_MAX : x;
`else
    return x;
`endif
  endfunction

  function automatic int m_need();
    int diff;
    diff = (m_t > m_d0) ? (m_t - m_d0) : (m_d0 - m_t);
    return (diff + STEP - 1) / STEP;
  endfunction

  // Steps taken by edge e: one per PPS period boundaries strictly after acceptance.
  function automatic int m_k(input int e);
    int ee, s;
    if (!m_seg || e < m_a) return 0;
    ee = (e >= m_b) ? (m_b - 1) : e;
    s  = (ee / PERIOD - m_a / PERIOD) / PPS;
    return (s < m_need()) ? s : m_need();
  endfunction

  function automatic int m_duty(input int e);
    int k;
    if (!m_seg) return 0;
    k = m_k(e);
    if (k == m_need()) return m_t;
    return (m_t > m_d0) ? (m_d0 + k * STEP) : (m_d0 - k * STEP);
  endfunction

  function automatic bit m_busy(input int e);
    return m_seg && (e >= m_a) && (e < m_b) && (m_k(e) < m_need());
  endfunction

  function automatic bit m_done(input int e);
    if (!m_seg || e < m_a) return 1'b0;
    if (m_need() == 0) return (e == m_a);
    return (e > m_a) && (m_k(e) == m_need()) && (m_k(e - 1) < m_need());
  endfunction

  always @(negedge clk) begin : monitor
    int e;
    if (mon_en) begin
      e = edge_n;
      check("mon_duty", int'(duty_cycle), m_duty(e));
      check("mon_busy", int'(busy), int'(m_busy(e)));
      check("mon_done", int'(done), int'(m_done(e)));
      check("mon_ready", int'(cmd_ready), int'(!m_busy(e)));
      check("mon_tick", int'(period_tick), int'(reset && (e % PERIOD) == PERIOD - 1));
      if (done) done_total++;
      if (n_chk - n_pass > 20) mon_en = 1'b0;
    end
  end

  task automatic send_cmd(input int tgt);
    cmd_valid  = 1'b1;
    cmd_target = tgt[WIDTH-1:0];
    @(posedge clk);
    #1;
    m_d0      = m_duty(edge_n - 1);
    m_a       = edge_n;
    m_t       = clamp_t(tgt);
    m_b       = INF;
    m_seg     = 1'b1;
    done_base = done_total;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // mode 0: none, 1: abort once duty==param, 2: abort on an update edge, 3: abort at iteration param
  task automatic wait_idle(input int mode, input int param, input bit noise, output bit timeout);
    timeout = 1'b1;
    for (int i = 0; i < 40000; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      abort     = 1'b0;
      if (!m_busy(edge_n)) begin
        timeout = 1'b0;
        break;
      end
      if ((mode == 1 && m_duty(edge_n) == param) ||
          (mode == 2 && m_duty(edge_n + 1) != m_duty(edge_n)) ||
          (mode == 3 && i == param)) begin
        abort = 1'b1;
        m_b   = edge_n + 1;
      end else if (noise && (i % 256) == 100) begin
        cmd_valid  = 1'b1;
        cmd_target = 8'($urandom);
        check("ready_low_in_ramp", int'(cmd_ready), 0);
      end
    end
    cmd_valid = 1'b0;
  endtask

  typedef struct {
    int target;
    int abort_at;
    int exp_final;
    int exp_done;
    bit noise;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit to;
    int cur, tgt, start, mode;

    vecs[0] = '{64,  -1, 64, 1, 1'b0};
    vecs[1] = '{70,  -1, 70, 1, 1'b0};
    vecs[2] = '{0,   -1, 0,  1, 1'b0};
    vecs[3] = '{128, 32, 32, 0, 1'b1};
    vecs[4] = '{32,  -1, 32, 1, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_duty", int'(duty_cycle), 0);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_tick", int'(period_tick), 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      send_cmd(vecs[v].target);
      wait_idle((vecs[v].abort_at >= 0) ? 1 : 0, vecs[v].abort_at, vecs[v].noise, to);
      repeat (2) @(negedge clk);
      check("vec_timeout", int'(to), 0);
      check("vec_duty", int'(duty_cycle), vecs[v].exp_final);
      check("vec_busy", int'(busy), 0);
      check("vec_ready", int'(cmd_ready), 1);
      check("vec_done_count", done_total - done_base, vecs[v].exp_done);
    end

    // Abort outside a ramp has no effect.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_abort_duty", int'(duty_cycle), 32);
    check("hold_abort_busy", int'(busy), 0);

    // Full-scale request, then async reset in the middle of the return ramp.
    send_cmd(255);
    wait_idle(0, 0, 1'b0, to);
    @(negedge clk);
    check("full_timeout", int'(to), 0);
    check("full_duty", int'(duty_cycle), FULL_FINAL);
    check("full_done_count", done_total - done_base, 1);

    start = FULL_FINAL;
    send_cmd(200);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (m_duty(edge_n) != start) break;
    end
    check("down_first_step", int'(duty_cycle), start - STEP);
    repeat (100) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    m_seg = 1'b0;
    #1;
    check("async_rst_duty", int'(duty_cycle), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_ready", int'(cmd_ready), 1);
    check("async_rst_done", int'(done), 0);
    check("async_rst_tick", int'(period_tick), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Abort coinciding with a duty update drops that update.
    cur = m_duty(edge_n);
    send_cmd(cur + 40);
    wait_idle(2, 0, 1'b0, to);
    repeat (2) @(negedge clk);
    check("prio_timeout", int'(to), 0);
    check("prio_duty", int'(duty_cycle), cur);
    check("prio_busy", int'(busy), 0);
    check("prio_done_count", done_total - done_base, 0);

    for (int r = 0; r < 4; r++) begin
      cur  = m_duty(edge_n);
      tgt  = ($urandom_range(0, 1) == 1) ? cur + int'($urandom_range(1, 20))
                                         : cur - int'($urandom_range(1, 20));
      if (tgt < 0) tgt = 0;
      if (tgt > 255) tgt = 255;
      mode = int'($urandom_range(0, 2));
      send_cmd(tgt);
      wait_idle((mode == 1) ? 3 : mode, int'($urandom_range(50, 3000)),
                1'($urandom_range(0, 1)), to);
      @(negedge clk);
      check("rnd_timeout", int'(to), 0);
      check("rnd_duty", int'(duty_cycle), m_duty(edge_n));
      check("rnd_busy", int'(busy), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
